// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding and
// store-starvation defaults.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLdWait,
    StLdCapture,
    StCdbHold
  } arb_state_e;

  localparam int unsigned StarveLimitDefault = 2;

  // Width of a counter that must hold 0..limit; never narrower than one bit.
  function automatic int unsigned streak_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dm_prio_sel.sv
// Store-over-load priority select with a saturating store-streak counter that
// hands the port to a waiting load after STARVE_LIMIT consecutive store grants.
module dm_prio_sel
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld_valid,
  input  logic st_valid,
  output logic ld_grant,
  output logic st_grant
);

  localparam int unsigned StreakW = streak_width(STARVE_LIMIT);
  localparam logic [StreakW-1:0] Limit = StreakW'(STARVE_LIMIT);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               starved;

  always_comb begin
    starved  = ld_valid && (streak_q == Limit);
    st_grant = en && st_valid && !starved;
    ld_grant = en && ld_valid && !st_grant;
  end

  // Streak only counts stores that actually made a load wait.
  always_comb begin
    streak_d = streak_q;
    if (!ld_valid || ld_grant) begin
      streak_d = '0;
    end else if (st_grant && (streak_q != Limit)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Single data-memory port shared by the load buffer and ROB store commit; one
// access outstanding at a time, load results returned over a CDB handshake.
module dm_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_ROBEN,
  input  logic [31:0] ld_address,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [4:0]  st_ROBEN,
  input  logic [31:0] st_address,
  input  logic [31:0] st_data,
  output logic        dm_Read_en,
  output logic        dm_Write_en,
  output logic [4:0]  dm_ROBEN,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data,
  input  logic [31:0] MEMU_Result,
  input  logic        MEMU_invalid_address,
  output logic        cdb_valid,
  input  logic        cdb_ready,
  output logic [4:0]  cdb_ROBEN,
  output logic [31:0] cdb_Result,
  output logic        cdb_exception
);

  arb_state_e state_q, state_d;
  logic       grant_en;
  logic       ld_grant, st_grant;

  // Readies stay low while reset is held even though the state reads idle.
  assign grant_en = (state_q == StIdle) && !rst;
  assign ld_ready = ld_grant;
  assign st_ready = st_grant;

  dm_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_sel (
    .clk      (clk),
    .rst      (rst),
    .en       (grant_en),
    .ld_valid (ld_valid),
    .st_valid (st_valid),
    .ld_grant (ld_grant),
    .st_grant (st_grant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (ld_grant) state_d = StLdWait;
      StLdWait:    state_d = StLdCapture;
      StLdCapture: state_d = StCdbHold;
      StCdbHold:   if (cdb_ready) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory request: enables pulse for one cycle, fields hold between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_Read_en  <= 1'b0;
      dm_Write_en <= 1'b0;
      dm_ROBEN    <= '0;
      dm_address  <= '0;
      dm_data     <= '0;
    end else begin
      dm_Read_en  <= ld_grant;
      dm_Write_en <= st_grant;
      if (st_grant) begin
        dm_ROBEN   <= st_ROBEN;
        dm_address <= st_address;
        dm_data    <= st_data;
      end else if (ld_grant) begin
        dm_ROBEN   <= ld_ROBEN;
        dm_address <= ld_address;
      end
    end
  end

  // dm_ROBEN still carries the load tag in capture since no grant can intervene.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid     <= 1'b0;
      cdb_ROBEN     <= '0;
      cdb_Result    <= '0;
      cdb_exception <= 1'b0;
    end else if (state_q == StLdCapture) begin
      cdb_valid     <= 1'b1;
      cdb_ROBEN     <= dm_ROBEN;
      cdb_Result    <= MEMU_Result;
      cdb_exception <= MEMU_invalid_address;
    end else if ((state_q == StCdbHold) && cdb_ready) begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a 1024-word synchronous memory model.
module tb_dm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_ROBEN;
  logic [31:0] ld_address;
  logic        st_valid, st_ready;
  logic [4:0]  st_ROBEN;
  logic [31:0] st_address, st_data;
  logic        dm_Read_en, dm_Write_en;
  logic [4:0]  dm_ROBEN;
  logic [31:0] dm_address, dm_data;
  logic [31:0] MEMU_Result;
  logic        MEMU_invalid_address;
  logic        cdb_valid, cdb_ready;
  logic [4:0]  cdb_ROBEN;
  logic [31:0] cdb_Result;
  logic        cdb_exception;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] mem_q;
  logic        inv_q;

  dm_port_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_valid             (ld_valid),
    .ld_ready             (ld_ready),
    .ld_ROBEN             (ld_ROBEN),
    .ld_address           (ld_address),
    .st_valid             (st_valid),
    .st_ready             (st_ready),
    .st_ROBEN             (st_ROBEN),
    .st_address           (st_address),
    .st_data              (st_data),
    .dm_Read_en           (dm_Read_en),
    .dm_Write_en          (dm_Write_en),
    .dm_ROBEN             (dm_ROBEN),
    .dm_address           (dm_address),
    .dm_data              (dm_data),
    .MEMU_Result          (MEMU_Result),
    .MEMU_invalid_address (MEMU_invalid_address),
    .cdb_valid            (cdb_valid),
    .cdb_ready            (cdb_ready),
    .cdb_ROBEN            (cdb_ROBEN),
    .cdb_Result           (cdb_Result),
    .cdb_exception        (cdb_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data valid the cycle after dm_Read_en.
  always @(posedge clk) begin
    if (rst) begin
      mem[5]   <= 32'd42;
      mem[7]   <= 32'd0;
      mem[976] <= 32'h0000_1234;
      mem_q    <= 32'd0;
      inv_q    <= 1'b0;
    end else begin
      if (dm_Write_en && (dm_address < 32'd1024)) mem[dm_address[9:0]] <= dm_data;
      if (dm_Read_en) begin
        mem_q <= (dm_address < 32'd1024) ? mem[dm_address[9:0]] : 32'hDEAD_BEEF;
        inv_q <= (dm_address >= 32'd1024);
      end
    end
  end
  assign MEMU_Result          = mem_q;
  assign MEMU_invalid_address = inv_q;

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ld_valid   = 1'b1;
    st_valid   = 1'b1;
    ld_ROBEN   = 5'd1;
    ld_address = 32'd5;
    st_ROBEN   = 5'd2;
    st_address = 32'd9;
    st_data    = 32'd9;
    cdb_ready  = 1'b0;

    // Reset state, with both requesters asserting.
    #12;
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_st_ready", st_ready, 1'b0);
    chk1("rst_rd_en", dm_Read_en, 1'b0);
    chk1("rst_wr_en", dm_Write_en, 1'b0);
    chk32("rst_dm_addr", dm_address, 32'd0);
    chk1("rst_cdb_valid", cdb_valid, 1'b0);
    chk1("rst_cdb_exc", cdb_exception, 1'b0);
    chk32("rst_cdb_res", cdb_Result, 32'd0);
    ld_valid = 1'b0;
    st_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Single load: addr 5, tag 3.
    ld_valid = 1'b1; ld_address = 32'd5; ld_ROBEN = 5'd3;
    #1;
    chk1("ld1_ready", ld_ready, 1'b1);
    chk1("ld1_st_ready", st_ready, 1'b0);
    cyc();
    ld_valid = 1'b0;
    chk1("ld1_rd_en", dm_Read_en, 1'b1);
    chk1("ld1_wr_en", dm_Write_en, 1'b0);
    chk32("ld1_dm_addr", dm_address, 32'd5);
    chk32("ld1_dm_rob", 32'(dm_ROBEN), 32'd3);
    cyc();
    chk1("ld1_rd_en_drop", dm_Read_en, 1'b0);
    chk1("ld1_cdb_early", cdb_valid, 1'b0);
    cyc();
    chk1("ld1_cdb_valid", cdb_valid, 1'b1);
    chk32("ld1_cdb_res", cdb_Result, 32'd42);
    chk32("ld1_cdb_rob", 32'(cdb_ROBEN), 32'd3);
    chk1("ld1_cdb_exc", cdb_exception, 1'b0);
    cdb_ready = 1'b1;
    cyc();
    chk1("ld1_cdb_clear", cdb_valid, 1'b0);
    cdb_ready = 1'b0;

    // Store 99 to addr 7, then load it back.
    st_valid = 1'b1; st_address = 32'd7; st_data = 32'd99; st_ROBEN = 5'd4;
    #1;
    chk1("st_ready", st_ready, 1'b1);
    cyc();
    chk1("st_wr_en", dm_Write_en, 1'b1);
    chk1("st_rd_en", dm_Read_en, 1'b0);
    chk32("st_dm_addr", dm_address, 32'd7);
    chk32("st_dm_data", dm_data, 32'd99);
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_address = 32'd7; ld_ROBEN = 5'd5;
    #1;
    chk1("raw_ld_ready", ld_ready, 1'b1);
    cyc();
    ld_valid = 1'b0;
    chk1("raw_wr_drop", dm_Write_en, 1'b0);
    chk1("raw_rd_en", dm_Read_en, 1'b1);
    cyc();
    cyc();
    chk1("raw_cdb_valid", cdb_valid, 1'b1);
    chk32("raw_cdb_res", cdb_Result, 32'd99);
    chk32("raw_cdb_rob", 32'(cdb_ROBEN), 32'd5);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;

    // Starvation: S, S, then L with both held high.
    st_valid = 1'b1; st_address = 32'd20; st_data = 32'd7; st_ROBEN = 5'd1;
    ld_valid = 1'b1; ld_address = 32'd5; ld_ROBEN = 5'd6;
    #1;
    chk1("sv1_st_ready", st_ready, 1'b1);
    chk1("sv1_ld_ready", ld_ready, 1'b0);
    cyc();
    chk1("sv2_wr_en", dm_Write_en, 1'b1);
    chk1("sv2_st_ready", st_ready, 1'b1);
    chk1("sv2_ld_ready", ld_ready, 1'b0);
    cyc();
    chk1("sv3_wr_en", dm_Write_en, 1'b1);
    chk1("sv3_st_ready", st_ready, 1'b0);
    chk1("sv3_ld_ready", ld_ready, 1'b1);
    cyc();
    chk1("sv4_rd_en", dm_Read_en, 1'b1);
    chk1("sv4_wr_en", dm_Write_en, 1'b0);
    chk1("sv4_st_blocked", st_ready, 1'b0);
    cyc();
    chk1("sv5_st_blocked", st_ready, 1'b0);
    cyc();
    chk1("sv6_cdb_valid", cdb_valid, 1'b1);
    chk32("sv6_cdb_res", cdb_Result, 32'd42);
    chk32("sv6_cdb_rob", 32'(cdb_ROBEN), 32'd6);

    // CDB back-pressure for four more cycles, then accept.
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("hold_valid", cdb_valid, 1'b1);
      chk32("hold_res", cdb_Result, 32'd42);
      chk32("hold_rob", 32'(cdb_ROBEN), 32'd6);
      chk1("hold_st_ready", st_ready, 1'b0);
      chk1("hold_ld_ready", ld_ready, 1'b0);
      chk1("hold_wr_en", dm_Write_en, 1'b0);
    end
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;
    chk1("hold_accept", cdb_valid, 1'b0);
    chk1("post_hold_st_ready", st_ready, 1'b1);
    chk1("post_hold_ld_ready", ld_ready, 1'b0);
    st_valid = 1'b0;
    ld_valid = 1'b0;
    cyc();

    // Out-of-range load and store.
    ld_valid = 1'b1; ld_address = 32'd2000; ld_ROBEN = 5'd7;
    cyc();
    ld_valid = 1'b0;
    chk32("bad_ld_addr", dm_address, 32'd2000);
    cyc();
    cyc();
    chk1("bad_ld_valid", cdb_valid, 1'b1);
    chk1("bad_ld_exc", cdb_exception, 1'b1);
    chk32("bad_ld_rob", 32'(cdb_ROBEN), 32'd7);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;
    st_valid = 1'b1; st_address = 32'd2000; st_data = 32'd555; st_ROBEN = 5'd8;
    #1;
    chk1("bad_st_ready", st_ready, 1'b1);
    cyc();
    st_valid = 1'b0;
    chk1("bad_st_wr_en", dm_Write_en, 1'b1);
    chk32("bad_st_addr", dm_address, 32'd2000);
    ld_valid = 1'b1; ld_address = 32'd976; ld_ROBEN = 5'd9;
    #1;
    chk1("bad_st_no_hang", ld_ready, 1'b1);
    cyc();
    ld_valid = 1'b0;
    cyc();
    cyc();
    chk1("alias_valid", cdb_valid, 1'b1);
    chk32("alias_res", cdb_Result, 32'h0000_1234);
    chk1("alias_exc", cdb_exception, 1'b0);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;

    // Reset while a load is in flight.
    ld_valid = 1'b1; ld_address = 32'd5; ld_ROBEN = 5'd10;
    cyc();
    ld_valid = 1'b0;
    chk1("mid_rd_en", dm_Read_en, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_rd_en", dm_Read_en, 1'b0);
    chk32("mid_rst_addr", dm_address, 32'd0);
    chk32("mid_rst_rob", 32'(dm_ROBEN), 32'd0);
    chk1("mid_rst_cdb", cdb_valid, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("mid_no_spurious", cdb_valid, 1'b0);
    end
    ld_valid = 1'b1; ld_address = 32'd5; ld_ROBEN = 5'd11;
    cyc();
    ld_valid = 1'b0;
    cyc();
    cyc();
    chk1("mid_new_valid", cdb_valid, 1'b1);
    chk32("mid_new_res", cdb_Result, 32'd42);
    chk32("mid_new_rob", 32'(cdb_ROBEN), 32'd11);
    cdb_ready = 1'b1;
    cyc();
    cdb_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
